ctrl_decode_queue: RTL and testbench



---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/ctrl_opcode_decode.sv | 41 ++++
 rtl/ctrl_decode_queue.sv | 120 ++++++++++++
 tb/tb_ctrl_decode_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, result/jump encodings and the control bundle
// produced by the opcode decoder and stored in the decode queue.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_PCIMM = 2'b11;

  localparam logic [1:0] J_NONE = 2'b00;
  localparam logic [1:0] J_JAL  = 2'b01;
  localparam logic [1:0] J_JALR = 2'b10;

  typedef struct packed {
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Branch;
    logic [1:0] ALUOp;
    logic [1:0] J;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational main decoder: opcode to control bundle. Unknown opcodes
// produce an all-zero bundle with only the illegal flag set.
module ctrl_opcode_decode
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_AUIPC = 1'b1
) (
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_LOAD:   begin ctrl.RegWrite = 1'b1; ctrl.ALUSrc = 1'b1; ctrl.ResultSrc = RES_MEM; end
      OP_STORE:  begin ctrl.ImmSrc = 3'b001; ctrl.ALUSrc = 1'b1; ctrl.MemWrite = 1'b1; end
      OP_IALU:   begin ctrl.RegWrite = 1'b1; ctrl.ALUSrc = 1'b1; ctrl.ALUOp = 2'b10; end
      OP_LUI:    begin
        ctrl.RegWrite = 1'b1; ctrl.ImmSrc = 3'b100; ctrl.ALUSrc = 1'b1; ctrl.ALUOp = 2'b11;
      end
      OP_AUIPC:  begin
        if (SUPPORT_AUIPC) begin
          ctrl.RegWrite = 1'b1; ctrl.ImmSrc = 3'b100; ctrl.ALUSrc = 1'b1;
          ctrl.ResultSrc = RES_PCIMM;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_R:      begin ctrl.RegWrite = 1'b1; ctrl.ALUOp = 2'b10; end
      OP_BRANCH: begin ctrl.ImmSrc = 3'b010; ctrl.Branch = 1'b1; ctrl.ALUOp = 2'b01; end
      OP_JAL:    begin
        ctrl.RegWrite = 1'b1; ctrl.ImmSrc = 3'b011; ctrl.ResultSrc = RES_PC4; ctrl.J = J_JAL;
      end
      OP_JALR:   begin
        ctrl.RegWrite = 1'b1; ctrl.ALUSrc = 1'b1; ctrl.ResultSrc = RES_PC4; ctrl.J = J_JALR;
      end
      default:   ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_queue.sv
// Decode stage between fetch and execute: decodes each accepted instruction
// into a control bundle and queues it with its pc/funct3 in a DEPTH-entry FIFO.
module ctrl_decode_queue
  import ctrl_pkg::*;
#(
  parameter int DEPTH         = 2,
  parameter bit SUPPORT_AUIPC = 1'b1,
  parameter int PC_W          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_funct3,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            Branch,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUOp,
  output logic [1:0]      J,
  output logic            illegal,
  output logic            trap_pending,
  input  logic            trap_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [2:0]      funct3;
    ctrl_t           ctrl;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          trap_q, trap_d;
  ctrl_t         dec_ctrl;
  entry_t        new_entry, head;
  logic          push, pop;
  logic          unused_instr_bits;

  ctrl_opcode_decode #(.SUPPORT_AUIPC(SUPPORT_AUIPC)) u_decode (
    .op   (instr[6:0]),
    .ctrl (dec_ctrl)
  );

  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};
  assign new_entry = '{pc: pc, funct3: instr[14:12], ctrl: dec_ctrl};

  assign in_ready  = !trap_q && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  // Flush wins over any handshake in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    trap_d   = trap_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW + 1)'(1);
      else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end
    // A trap raised by the popped entry takes priority over a clear.
    if (pop && head.ctrl.illegal) trap_d = 1'b1;
    else if (trap_clr)            trap_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      trap_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      trap_q   <= trap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  // Stale storage is never exposed: an empty queue presents all zeros.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc       = head.pc;
  assign out_funct3   = head.funct3;
  assign RegWrite     = head.ctrl.RegWrite;
  assign MemWrite     = head.ctrl.MemWrite;
  assign ALUSrc       = head.ctrl.ALUSrc;
  assign Branch       = head.ctrl.Branch;
  assign ImmSrc       = head.ctrl.ImmSrc;
  assign ResultSrc    = head.ctrl.ResultSrc;
  assign ALUOp        = head.ctrl.ALUOp;
  assign J            = head.ctrl.J;
  assign illegal      = head.ctrl.illegal;
  assign trap_pending = trap_q;

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench for ctrl_decode_queue: expected bundles are queued on push
// and compared against the head every cycle; a second instance has AUIPC off.
module tb_ctrl_decode_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, out_pc;
  logic [2:0]  out_funct3, ImmSrc;
  logic        RegWrite, MemWrite, ALUSrc, Branch, illegal, trap_pending, trap_clr = 1'b0;
  logic [1:0]  ResultSrc, ALUOp, J;
  logic [13:0] obs_ctrl;

  logic        na_in_valid = 1'b0, na_in_ready, na_out_valid, na_out_ready = 1'b0;
  logic [31:0] na_instr = '0, na_out_pc;
  logic [2:0]  na_out_funct3, na_ImmSrc;
  logic        na_RegWrite, na_MemWrite, na_ALUSrc, na_Branch, na_illegal, na_trap;
  logic [1:0]  na_ResultSrc, na_ALUOp, na_J;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [13:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  logic        trap_m = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [6:0]  ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                           7'b0110111, 7'b0010111, 7'b1100111, 7'b1101111};

  always #5 clk = ~clk;

  ctrl_decode_queue #(.DEPTH(DEPTH), .SUPPORT_AUIPC(1'b1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_funct3(out_funct3), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .Branch(Branch), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .J(J),
    .illegal(illegal), .trap_pending(trap_pending), .trap_clr(trap_clr)
  );

  ctrl_decode_queue #(.DEPTH(DEPTH), .SUPPORT_AUIPC(1'b0), .PC_W(32)) dut_na (
    .clk(clk), .rst(rst), .in_valid(na_in_valid), .in_ready(na_in_ready), .instr(na_instr),
    .pc(32'h0000_0400), .flush(1'b0), .out_valid(na_out_valid), .out_ready(na_out_ready),
    .out_pc(na_out_pc), .out_funct3(na_out_funct3), .RegWrite(na_RegWrite),
    .MemWrite(na_MemWrite), .ALUSrc(na_ALUSrc), .Branch(na_Branch), .ImmSrc(na_ImmSrc),
    .ResultSrc(na_ResultSrc), .ALUOp(na_ALUOp), .J(na_J), .illegal(na_illegal),
    .trap_pending(na_trap), .trap_clr(1'b0)
  );

  assign obs_ctrl = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, J, illegal};

  // Bundle order: RegWrite ImmSrc ALUSrc MemWrite ResultSrc Branch ALUOp J illegal.
  function automatic logic [13:0] exp_ctrl(input logic [6:0] op, input bit auipc_en);
    case (op)
      7'b0000011: return 14'b1_000_1_0_01_0_00_00_0;
      7'b0100011: return 14'b0_001_1_1_00_0_00_00_0;
      7'b0010011: return 14'b1_000_1_0_00_0_10_00_0;
      7'b0110111: return 14'b1_100_1_0_00_0_11_00_0;
      7'b0010111: return auipc_en ? 14'b1_100_1_0_11_0_00_00_0 : 14'b0_000_0_0_00_0_00_00_1;
      7'b0110011: return 14'b1_000_0_0_00_0_10_00_0;
      7'b1100011: return 14'b0_010_0_0_00_1_01_00_0;
      7'b1101111: return 14'b1_011_0_0_10_0_00_01_0;
      7'b1100111: return 14'b1_000_1_0_10_0_00_10_0;
      default:    return 14'b0_000_0_0_00_0_00_00_1;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], op};
  endfunction

  // One clock of stimulus: check the presented state, update the model, advance.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic tclr, output logic acc);
    logic exp_rdy, pop_f, push_f;
    exp_t h;
    in_valid = iv; instr = ins; pc = p; out_ready = ordy; flush = fl; trap_clr = tclr;
    #1;
    exp_rdy = !trap_m && (sb.size() < DEPTH);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, sb.size() != 0);
    check_eq("trap_pending", trap_pending, trap_m);
    if (sb.size() != 0) h = sb[0];
    else h = '{pc: 32'h0, f3: 3'h0, ctrl: 14'h0};
    check_eq("head_ctrl", obs_ctrl, h.ctrl);
    check_eq("head_pc", out_pc, h.pc);
    check_eq("head_funct3", out_funct3, h.f3);
    pop_f  = ordy && (sb.size() != 0) && !fl;
    push_f = iv && exp_rdy && !fl;
    if (pop_f && h.ctrl[0]) trap_m = 1'b1;
    else if (tclr)          trap_m = 1'b0;
    if (fl) sb.delete();
    else begin
      if (pop_f)  void'(sb.pop_front());
      if (push_f) sb.push_back('{pc: p, f3: ins[14:12], ctrl: exp_ctrl(ins[6:0], 1'b1)});
    end
    acc = push_f;
    $display("cyc iv=%0b ins=%08h pc=%08h ordy=%0b fl=%0b clr=%0b push=%0b pop=%0b depth=%0d",
             iv, ins, p, ordy, fl, tclr, push_f, pop_f, sb.size());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, acc);
  endtask

  task automatic push_op(input logic [6:0] op, input logic [31:0] p, input logic ordy);
    logic acc;
    cycle(1'b1, mk_instr(op), p, ordy, 1'b0, 1'b0, acc);
  endtask

  // mode 0: sink stalled for the first 4 cycles, then always ready; mode 1: random sink.
  task automatic run_stream(input int n, input int mode);
    int sent = 0;
    int guard = 0;
    logic acc, ordy;
    logic [31:0] ins, p;
    ins = mk_instr(ops[0]);
    p = $urandom();
    while ((sent < n || sb.size() != 0) && guard < 500) begin
      ordy = (mode == 0) ? (guard >= 4) : ($urandom_range(0, 1) == 1);
      cycle(sent < n, ins, p, ordy, 1'b0, 1'b0, acc);
      if (acc) begin
        sent++;
        ins = mk_instr(ops[sent % 9]);
        p = $urandom();
      end
      guard++;
    end
    if (guard >= 500) check_eq("stream_budget", guard, 0);
  endtask

  initial begin
    logic acc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle(1'b0);
    idle(1'b1);

    // JAL held at the head, then consumed.
    cycle(1'b1, {25'h0, 7'b1101111}, 32'h100, 1'b0, 1'b0, 1'b0, acc);
    check_eq("jal_J", J, 2'b01);
    check_eq("jal_ResultSrc", ResultSrc, 2'b10);
    check_eq("jal_out_pc", out_pc, 32'h100);
    idle(1'b1);
    idle(1'b0);

    // Fill/backpressure with Load, Store, R, Branch..., then random sink across wrap.
    run_stream(9, 0);
    run_stream(24, 1);

    // Illegal opcode raises a sticky trap that blocks input until cleared.
    push_op(7'b0000000, 32'h200, 1'b0);
    push_op(7'b0000011, 32'h204, 1'b0);
    idle(1'b1);
    push_op(7'b0110011, 32'h208, 1'b1);
    push_op(7'b0110011, 32'h20c, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);

    // Trap set and clear in the same cycle: set wins.
    push_op(7'b1111111, 32'h300, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);

    // Flush with two queued entries plus a concurrent push and pop.
    push_op(7'b0010011, 32'h400, 1'b0);
    push_op(7'b0110111, 32'h404, 1'b0);
    cycle(1'b1, mk_instr(7'b0100011), 32'h408, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b0);
    run_stream(5, 1);

    // Asynchronous reset mid-operation.
    push_op(7'b0000011, 32'h500, 1'b0);
    push_op(7'b0000000, 32'h504, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    check_eq("arst_ctrl", obs_ctrl, 14'h0);
    check_eq("arst_out_pc", out_pc, 32'h0);
    sb.delete();
    trap_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b0);
    run_stream(4, 1);

    // AUIPC with support disabled decodes as illegal and traps.
    check_eq("na_in_ready", na_in_ready, 1'b1);
    na_in_valid = 1'b1;
    na_instr = {25'h0, 7'b0010111};
    @(posedge clk);
    #1;
    na_in_valid = 1'b0;
    na_out_ready = 1'b1;
    check_eq("na_out_valid", na_out_valid, 1'b1);
    check_eq("na_illegal", na_illegal, 1'b1);
    check_eq("na_ctrl", {na_RegWrite, na_ImmSrc, na_ResultSrc}, 6'h0);
    check_eq("na_out_pc", na_out_pc, 32'h400);
    @(posedge clk);
    #1;
    na_out_ready = 1'b0;
    check_eq("na_trap", na_trap, 1'b1);
    check_eq("na_in_ready_trap", na_in_ready, 1'b0);
    check_eq("na_empty", na_out_valid, 1'b0);
    $display("na: auipc pushed and popped, trap=%0b", na_trap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
